// File: rtl/example_lane_controller.sv
// Serial-lane bring-up controller: transceiver reset, comma alignment by bit-slip,
// drive-strength escalation on timeout, and registered user data paths once locked.
module example_lane_controller #(
  parameter int         RESET_CYCLES = 16,
  parameter int         LOCK_COUNT   = 8,
  parameter int         TIMEOUT      = 1023,
  parameter logic [9:0] COMMA        = 10'b0011111010
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       retrain,
  output logic       xcvr_reset,
  output logic [9:0] data_tx,
  input  logic [9:0] data_rx,
  output logic [3:0] txSwing,
  output logic       cdrMode,
  input  logic [9:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  output logic       locked,
  output logic       failed,
  output logic [3:0] align_offset
);

  localparam int RCW = $clog2(RESET_CYCLES + 1);
  localparam int MCW = $clog2(LOCK_COUNT + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_RESET_XCVR, S_TRAIN, S_LOCKED, S_FAILED} state_t;

  state_t         state_q, state_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [MCW-1:0] match_cnt_q, match_cnt_d;
  logic [TCW-1:0] train_cnt_q, train_cnt_d;
  logic [3:0]     align_offset_q, align_offset_d;
  logic [3:0]     tx_swing_q, tx_swing_d;
  logic           blank_q, blank_d;
  logic [9:0]     prev_rx_q, prev_rx_d;
  logic [9:0]     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic [9:0]     data_tx_q, data_tx_d;
  logic           xcvr_reset_q, xcvr_reset_d;
  logic           cdr_mode_q, cdr_mode_d;
  logic           tx_ready_q, tx_ready_d;
  logic           locked_q, locked_d;
  logic           failed_q, failed_d;

  logic [19:0]    window_s;
  logic [9:0]     aligned_s;

  // Bit-slip window: the aligned word spans the previous and current receive words.
  always_comb begin
    window_s = {data_rx, prev_rx_q};
    case (align_offset_q)
      4'd0:    aligned_s = window_s[9:0];
      4'd1:    aligned_s = window_s[10:1];
      4'd2:    aligned_s = window_s[11:2];
      4'd3:    aligned_s = window_s[12:3];
      4'd4:    aligned_s = window_s[13:4];
      4'd5:    aligned_s = window_s[14:5];
      4'd6:    aligned_s = window_s[15:6];
      4'd7:    aligned_s = window_s[16:7];
      4'd8:    aligned_s = window_s[17:8];
      4'd9:    aligned_s = window_s[18:9];
      default: aligned_s = window_s[9:0];
    endcase
  end

  // Next-state and datapath logic; retrain overrides everything computed above it.
  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    match_cnt_d    = match_cnt_q;
    train_cnt_d    = train_cnt_q;
    align_offset_d = align_offset_q;
    tx_swing_d     = tx_swing_q;
    blank_d        = blank_q;
    prev_rx_d      = data_rx;
    rx_data_d      = aligned_s;
    rx_valid_d     = 1'b0;
    data_tx_d      = COMMA;

    case (state_q)
      S_RESET_XCVR: begin
        match_cnt_d = '0;
        train_cnt_d = '0;
        blank_d     = 1'b0;
        if (rst_cnt_q == RCW'(RESET_CYCLES - 1)) begin
          state_d   = S_TRAIN;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      S_TRAIN: begin
        train_cnt_d = train_cnt_q + TCW'(1);
        // A slip corrupts the next window, so the cycle after it is never compared.
        if (blank_q) begin
          blank_d = 1'b0;
        end else if (aligned_s == COMMA) begin
          match_cnt_d = match_cnt_q + MCW'(1);
        end else begin
          match_cnt_d    = '0;
          align_offset_d = (align_offset_q == 4'd9) ? 4'd0 : align_offset_q + 4'd1;
          blank_d        = 1'b1;
        end
        if (match_cnt_d == MCW'(LOCK_COUNT)) begin
          state_d = S_LOCKED;
        end else if (train_cnt_d == TCW'(TIMEOUT)) begin
          if (tx_swing_q != 4'd15) begin
            tx_swing_d = tx_swing_q + 4'd1;
            state_d    = S_RESET_XCVR;
            rst_cnt_d  = '0;
          end else begin
            state_d = S_FAILED;
          end
        end else begin
          state_d = S_TRAIN;
        end
      end
      S_LOCKED: begin
        rx_valid_d = (aligned_s != COMMA);
        data_tx_d  = tx_valid ? tx_data : COMMA;
      end
      S_FAILED: begin
        state_d = S_FAILED;
      end
      default: begin
        state_d = S_RESET_XCVR;
      end
    endcase

    if (retrain) begin
      state_d        = S_RESET_XCVR;
      rst_cnt_d      = '0;
      match_cnt_d    = '0;
      train_cnt_d    = '0;
      align_offset_d = 4'd0;
      blank_d        = 1'b0;
      rx_valid_d     = 1'b0;
      data_tx_d      = COMMA;
    end else begin
      blank_d = blank_d;
    end

    xcvr_reset_d = (state_d == S_RESET_XCVR) || (state_d == S_FAILED);
    cdr_mode_d   = (state_d != S_LOCKED);
    tx_ready_d   = (state_d == S_LOCKED);
    locked_d     = (state_d == S_LOCKED);
    failed_d     = (state_d == S_FAILED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_RESET_XCVR;
      rst_cnt_q      <= '0;
      match_cnt_q    <= '0;
      train_cnt_q    <= '0;
      align_offset_q <= 4'd0;
      tx_swing_q     <= 4'd8;
      blank_q        <= 1'b0;
      prev_rx_q      <= 10'd0;
      rx_data_q      <= 10'd0;
      rx_valid_q     <= 1'b0;
      data_tx_q      <= COMMA;
      xcvr_reset_q   <= 1'b1;
      cdr_mode_q     <= 1'b1;
      tx_ready_q     <= 1'b0;
      locked_q       <= 1'b0;
      failed_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      match_cnt_q    <= match_cnt_d;
      train_cnt_q    <= train_cnt_d;
      align_offset_q <= align_offset_d;
      tx_swing_q     <= tx_swing_d;
      blank_q        <= blank_d;
      prev_rx_q      <= prev_rx_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      data_tx_q      <= data_tx_d;
      xcvr_reset_q   <= xcvr_reset_d;
      cdr_mode_q     <= cdr_mode_d;
      tx_ready_q     <= tx_ready_d;
      locked_q       <= locked_d;
      failed_q       <= failed_d;
    end
  end

  assign xcvr_reset   = xcvr_reset_q;
  assign data_tx      = data_tx_q;
  assign txSwing      = tx_swing_q;
  assign cdrMode      = cdr_mode_q;
  assign tx_ready     = tx_ready_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign locked       = locked_q;
  assign failed       = failed_q;
  assign align_offset = align_offset_q;

endmodule

// File: tb/tb_example_lane_controller.sv
// Directed bench for example_lane_controller: bring-up timing, bit-slip alignment,
// locked data paths (table-driven), timeout escalation, retrain and reset.
module tb_example_lane_controller;

  localparam logic [9:0] C = 10'h0FA;

  logic       clock;
  logic       reset;
  logic       retrain;
  logic       xcvr_reset;
  logic [9:0] data_tx;
  logic [9:0] data_rx;
  logic [3:0] txSwing;
  logic       cdrMode;
  logic [9:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       locked;
  logic       failed;
  logic [3:0] align_offset;

  logic [1:0] mode;
  logic [9:0] tb_rx;
  int         cyc;
  int         total;
  int         bad;

  typedef struct {
    logic       tv;
    logic [9:0] td;
    logic [9:0] rx;
    logic [9:0] e_tx;
    logic [9:0] e_rx;
    logic       e_rv;
  } vec_t;

  vec_t vecs [8];

  example_lane_controller dut (
    .clock(clock), .reset(reset), .retrain(retrain), .xcvr_reset(xcvr_reset),
    .data_tx(data_tx), .data_rx(data_rx), .txSwing(txSwing), .cdrMode(cdrMode),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .locked(locked), .failed(failed), .align_offset(align_offset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Receive source: bench word, straight loopback, or loopback rotated left by 3.
  always_comb begin
    data_rx = tb_rx;
    case (mode)
      2'd1:    data_rx = data_tx;
      2'd2:    data_rx = {data_tx[6:0], data_tx[9:7]};
      default: data_rx = tb_rx;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cyc = 1;
  endtask

  task automatic do_retrain();
    retrain = 1'b1;
    step();
    retrain = 1'b0;
    cyc = 1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_xcvr_reset"}, 32'(xcvr_reset), 32'd1);
    chk({tag, "_data_tx"}, 32'(data_tx), 32'(C));
    chk({tag, "_txSwing"}, 32'(txSwing), 32'd8);
    chk({tag, "_cdrMode"}, 32'(cdrMode), 32'd1);
    chk({tag, "_align_offset"}, 32'(align_offset), 32'd0);
    chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_failed"}, 32'(failed), 32'd0);
  endtask

  initial begin
    int guard;
    total = 0; bad = 0; cyc = 0;
    reset = 1'b1; retrain = 1'b0; tx_valid = 1'b0; tx_data = 10'd0;
    mode = 2'd1; tb_rx = 10'd0;

    // rx expectations lag one row: rx_data shows the word driven two cycles earlier.
    vecs[0] = '{1'b1, 10'h155, 10'h3FF, 10'h155, C,       1'b0};
    vecs[1] = '{1'b0, 10'h2AA, 10'h000, C,       10'h3FF, 1'b1};
    vecs[2] = '{1'b1, 10'h2AA, 10'h123, 10'h2AA, 10'h000, 1'b1};
    vecs[3] = '{1'b1, 10'h000, C,       10'h000, 10'h123, 1'b1};
    vecs[4] = '{1'b0, 10'h3FF, C,       C,       C,       1'b0};
    vecs[5] = '{1'b1, C,       10'h2C1, C,       C,       1'b0};
    vecs[6] = '{1'b1, 10'h3FF, 10'h055, 10'h3FF, 10'h2C1, 1'b1};
    vecs[7] = '{1'b0, 10'h111, 10'h000, C,       10'h055, 1'b1};

    // Zero-skew loopback bring-up.
    do_reset();
    chk_reset_vals("rst");
    run_to(16);
    chk("xcvr_reset_c16", 32'(xcvr_reset), 32'd1);
    step();
    chk("xcvr_reset_c17", 32'(xcvr_reset), 32'd0);
    chk("cdr_train", 32'(cdrMode), 32'd1);
    chk("data_tx_train", 32'(data_tx), 32'(C));
    run_to(24);
    chk("locked_c24", 32'(locked), 32'd0);
    step();
    chk("locked_c25", 32'(locked), 32'd1);
    chk("offset_c25", 32'(align_offset), 32'd0);
    chk("cdr_locked", 32'(cdrMode), 32'd0);
    chk("tx_ready_locked", 32'(tx_ready), 32'd1);

    // Table-driven locked data paths; includes runs of non-user words.
    mode = 2'd0;
    for (int i = 0; i < 8; i++) begin
      tx_valid = vecs[i].tv;
      tx_data  = vecs[i].td;
      tb_rx    = vecs[i].rx;
      step();
      chk($sformatf("vec%0d_data_tx", i), 32'(data_tx), 32'(vecs[i].e_tx));
      chk($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].e_rx));
      chk($sformatf("vec%0d_rx_valid", i), 32'(rx_valid), 32'(vecs[i].e_rv));
      chk($sformatf("vec%0d_locked", i), 32'(locked), 32'd1);
    end

    // Loopback user word 0x155.
    tx_valid = 1'b0;
    mode = 2'd1;
    step(); step(); step();
    tx_valid = 1'b1; tx_data = 10'h155;
    step();
    tx_valid = 1'b0;
    chk("lb_data_tx", 32'(data_tx), 32'h155);
    step();
    step();
    chk("lb_rx_valid", 32'(rx_valid), 32'd1);
    chk("lb_rx_data", 32'(rx_data), 32'h155);
    step();
    chk("lb_rx_valid_after", 32'(rx_valid), 32'd0);

    // Retrain into a 3-bit rotated loopback; tx_data must be ignored while not locked.
    mode = 2'd2;
    tx_valid = 1'b1; tx_data = 10'h155;
    do_retrain();
    chk("rt_locked", 32'(locked), 32'd0);
    chk("rt_xcvr_reset", 32'(xcvr_reset), 32'd1);
    chk("rt_data_tx", 32'(data_tx), 32'(C));
    step();
    chk("rt_tx_ignored", 32'(data_tx), 32'(C));
    chk("rt_tx_ready", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    run_to(17);
    chk("rot_offset_c17", 32'(align_offset), 32'd0);
    step();
    chk("rot_offset_c18", 32'(align_offset), 32'd1);
    step();
    chk("rot_offset_blank_c19", 32'(align_offset), 32'd1);
    step();
    chk("rot_offset_c20", 32'(align_offset), 32'd2);
    run_to(22);
    chk("rot_offset_c22", 32'(align_offset), 32'd3);
    run_to(30);
    chk("rot_locked_c30", 32'(locked), 32'd0);
    step();
    chk("rot_locked_c31", 32'(locked), 32'd1);
    chk("rot_offset_c31", 32'(align_offset), 32'd3);

    // Two timeouts to reach txSwing=10, then lock and retrain.
    mode = 2'd0; tb_rx = 10'h000;
    do_reset();
    run_to(1039);
    chk("to1_swing", 32'(txSwing), 32'd8);
    chk("to1_xcvr", 32'(xcvr_reset), 32'd0);
    step();
    chk("to1_swing_after", 32'(txSwing), 32'd9);
    chk("to1_xcvr_after", 32'(xcvr_reset), 32'd1);
    run_to(2079);
    chk("to2_swing_after", 32'(txSwing), 32'd10);
    mode = 2'd1;
    guard = 0;
    while (!locked && guard < 200) begin
      step();
      guard++;
    end
    chk("lock_wait", 32'(locked), 32'd1);
    chk("lock_swing", 32'(txSwing), 32'd10);
    do_retrain();
    chk("rt10_locked", 32'(locked), 32'd0);
    chk("rt10_offset", 32'(align_offset), 32'd0);
    chk("rt10_swing", 32'(txSwing), 32'd10);
    chk("rt10_xcvr", 32'(xcvr_reset), 32'd1);

    // Full escalation to FAILED with data_rx held at zero.
    mode = 2'd0; tb_rx = 10'h000;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      run_to(1039 * (k + 1));
      chk($sformatf("esc%0d_swing", k), 32'(txSwing), 32'(8 + k));
      chk($sformatf("esc%0d_failed", k), 32'(failed), 32'd0);
      step();
      chk($sformatf("esc%0d_swing_after", k), 32'(txSwing), (k < 7) ? 32'(9 + k) : 32'd15);
      chk($sformatf("esc%0d_xcvr_after", k), 32'(xcvr_reset), 32'd1);
      chk($sformatf("esc%0d_failed_after", k), 32'(failed), (k == 7) ? 32'd1 : 32'd0);
    end
    run_to(8313 + 40);
    chk("failed_sticky", 32'(failed), 32'd1);
    chk("failed_xcvr", 32'(xcvr_reset), 32'd1);
    chk("failed_data_tx", 32'(data_tx), 32'(C));
    chk("failed_locked", 32'(locked), 32'd0);
    do_retrain();
    chk("rtf_failed", 32'(failed), 32'd0);
    chk("rtf_xcvr", 32'(xcvr_reset), 32'd1);
    chk("rtf_swing", 32'(txSwing), 32'd15);

    // Reset in TRAIN with align_offset=5, txSwing=12.
    do_reset();
    run_to(1 + 4 * 1039);
    chk("pre_swing12", 32'(txSwing), 32'd12);
    guard = 0;
    while (!(xcvr_reset == 1'b0 && align_offset == 4'd5) && guard < 200) begin
      step();
      guard++;
    end
    chk("train_offset5_found", 32'(align_offset), 32'd5);
    chk("train_swing12", 32'(txSwing), 32'd12);
    do_reset();
    chk_reset_vals("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/example_lane_controller.md
EXAMPLE_LANE_CONTROLLER -- requirements
Module: example_lane_controller

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- RESET_CYCLES, 16, cycles xcvr_reset is held high per bring-up attempt.
- LOCK_COUNT, 8, consecutive aligned commas required to declare lock.
- TIMEOUT, 1023, maximum TRAIN cycles per attempt.
- COMMA, 10'b0011111010, training/idle symbol.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning. All ports are synchronous to clock.
- clock, in, 1, single clock (transceiver slowClk domain).
- reset, in, 1, synchronous, active-high.
- retrain, in, 1, pulse: restart bring-up from RESET_XCVR.
- xcvr_reset, out, 1, transceiver reset.
- data_tx, out, 10, transceiver transmit word.
- data_rx, in, 10, transceiver receive word.
- txSwing, out, 4, transceiver drive-strength setting.
- cdrMode, out, 1, 1 = fast-acquire CDR, 0 = tracking.
- tx_data, in, 10, user transmit word.
- tx_valid, in, 1, tx_data valid.
- tx_ready, out, 1, controller accepts tx_data.
- rx_data, out, 10, aligned receive word.
- rx_valid, out, 1, rx_data is a non-COMMA user word.
- locked, out, 1, state == LOCKED.
- failed, out, 1, state == FAILED.
- align_offset, out, 4, current bit-slip offset, 0..9.

Function
REQ-003 States SHALL be RESET_XCVR, TRAIN, LOCKED and FAILED.
REQ-004 RESET_XCVR SHALL drive xcvr_reset=1 for exactly RESET_CYCLES cycles, clear match_cnt and train_cnt, and then enter TRAIN.
REQ-005 In RESET_XCVR and TRAIN, data_tx SHALL equal COMMA and cdrMode SHALL be 1.
REQ-006 prev_rx SHALL register data_rx every cycle; window = {data_rx, prev_rx} (20 bits); aligned = window[align_offset+9 : align_offset].
REQ-007 In TRAIN, if aligned == COMMA then match_cnt SHALL increment; otherwise match_cnt SHALL clear, align_offset SHALL advance (9 wraps to 0), and the next cycle SHALL be a blanking cycle in which no compare is made.
REQ-008 When match_cnt reaches LOCK_COUNT, the FSM SHALL enter LOCKED on the next cycle.
REQ-009 train_cnt SHALL count TRAIN cycles; at train_cnt == TIMEOUT without lock, the FSM SHALL take one of two paths.
- txSwing < 15: txSwing increments by 1 and the FSM returns to RESET_XCVR.
- txSwing == 15: the FSM enters FAILED.
REQ-010 If lock and timeout occur in the same cycle, lock SHALL win.
REQ-011 In LOCKED, cdrMode SHALL be 0 and tx_ready SHALL be 1.
REQ-012 In LOCKED, data_tx SHALL equal tx_data when tx_valid=1, else COMMA.
REQ-013 In LOCKED, data_tx SHALL be registered: a word accepted in cycle N appears on data_tx in cycle N+1.
REQ-014 tx_ready SHALL be 0 outside LOCKED, and tx_data SHALL be ignored there.
REQ-015 rx_data SHALL equal registered aligned (1-cycle latency).
REQ-016 rx_valid SHALL be 1 only in LOCKED with aligned != COMMA.
REQ-017 In LOCKED, 4 consecutive aligned words that are not valid user-traffic SHALL NOT cause unlock; the only LOCKED exits are retrain and reset.
REQ-018 FAILED SHALL be sticky: xcvr_reset=1, data_tx=COMMA, exited only by retrain or reset.
REQ-019 retrain SHALL take priority over all transitions except reset; it SHALL enter RESET_XCVR, clear align_offset, and preserve txSwing.
REQ-020 align_offset and txSwing SHALL change only as stated in REQ-007, REQ-009 and REQ-019.

Reset
REQ-021 On reset the block SHALL enter RESET_XCVR (with its RESET_CYCLES count restarted) and set the following, effective the cycle after reset is sampled high:
- xcvr_reset=1, data_tx=COMMA.
- txSwing=4'd8, cdrMode=1.
- align_offset=0, match_cnt=0, train_cnt=0.
- tx_ready=0, rx_valid=0, rx_data=0, prev_rx=0, locked=0, failed=0.
REQ-022 Reset asserted mid-operation (any state) SHALL behave identically to REQ-021.

Verification
REQ-023 Scenario: loopback data_tx->data_rx with 0-bit skew, defaults -> xcvr_reset high 16 cycles, locked asserts on cycle 16+8+1, align_offset=0.
REQ-024 Scenario: loopback with 3-bit rotation -> align_offset steps 0,1,2,3 with one blanking cycle per slip; locked after 8 consecutive matches; align_offset=3.
REQ-025 Scenario: data_rx held at 10'h000 -> timeout every 1023 TRAIN cycles; txSwing goes 8->9->...->15; next timeout -> failed=1, xcvr_reset=1.
REQ-026 Scenario: LOCKED, tx_valid=1 with tx_data=10'h155 -> data_tx=10'h155 the next cycle; in loopback rx_valid=1 with rx_data=10'h155.
REQ-027 Scenario: retrain pulse in LOCKED with txSwing=10 -> RESET_XCVR next cycle, locked=0, align_offset=0, txSwing stays 10.
REQ-028 Scenario: reset asserted in TRAIN with align_offset=5, txSwing=12 -> all REQ-021 values next cycle.
